// File: rtl/ping_pang_reader_if.sv
// Bus bundle between the ping-pong read controller and its environment:
// writer bank flags, RAM read port and the downstream word stream.
//
// Downstream handshake: a word moves when rd_valid & rd_ready are both high
// at a rising clock edge. Once rd_valid is raised it stays high, and rd_data
// and rd_last stay unchanged, until that transfer happens. rd_ready may
// change freely in any cycle.
interface ping_pang_reader_if #(
   parameter int DATA_W = 8,
   parameter int OFS_W  = 7
);
   logic [1:0]        bank_full;
   logic [1:0]        bank_release;
   logic              ram_rd_en;
   logic [OFS_W:0]    ram_rd_addr;
   logic [DATA_W-1:0] ram_rd_data;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic              rd_ready;
   logic              cur_bank;
   logic              busy;

   // Reader side: drives the RAM read port and the downstream stream.
   modport master (
      input  bank_full, ram_rd_data, rd_ready,
      output bank_release, ram_rd_en, ram_rd_addr, rd_data, rd_valid,
             rd_last, cur_bank, busy
   );

   // Environment side: writer, RAM and downstream consumer.
   modport slave (
      output bank_full, ram_rd_data, rd_ready,
      input  bank_release, ram_rd_en, ram_rd_addr, rd_data, rd_valid,
             rd_last, cur_bank, busy
   );
endinterface

// File: rtl/ping_pang_reader.sv
// Read-side controller of a two-bank ping-pong buffer. Waits for the expected
// bank to be marked full, reads it in address order, streams the words out
// through a 2-entry skid FIFO and pulses the bank's release bit when done.
// Banks are consumed strictly alternately starting with bank 0.
module ping_pang_reader #(
   parameter int DATA_W = 8,
   parameter int OFS_W  = 7
) (
   input  logic                 sys_clk,
   input  logic                 sys_rst,
   ping_pang_reader_if.master   bus,
   output logic [1:0]           o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_STREAM  = 2'd1,
      S_DRAIN   = 2'd2,
      S_RELEASE = 2'd3
   } state_t;

   localparam logic [OFS_W-1:0] LP_OFS_MAX = '1;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_cur_bank;
   logic [OFS_W-1:0]  r_offset;

   // One read may be in flight: its data shows up on ram_rd_data next cycle.
   logic              r_rd_pend;
   logic              r_pend_last;

   // Two-entry skid FIFO holding {last, data}.
   logic [DATA_W-1:0] r_mem_data [2];
   logic [1:0]        r_mem_last;
   logic              r_wptr;
   logic              r_rptr;
   logic [1:0]        r_count;

   logic              w_valid;
   logic              w_pop;
   logic              w_push;
   logic [1:0]        w_occ;
   logic              w_rd_ok;
   logic              w_rd_en;
   logic              w_release;
   logic              w_head_last;

   assign w_valid     = (r_count != 2'd0);
   assign w_pop       = w_valid & bus.rd_ready;
   assign w_push      = r_rd_pend;
   assign w_head_last = r_mem_last[r_rptr];

   // Slots committed after this cycle: stored words plus the in-flight read,
   // minus the word leaving now. A new read is allowed only while this is
   // below 2, so the FIFO can never overflow whatever rd_ready does.
   assign w_occ   = r_count + {1'b0, r_rd_pend} - {1'b0, w_pop};
   assign w_rd_ok = (w_occ < 2'd2);

   // Next-state and control strobes for the bank sequencing FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_release   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.bank_full[r_cur_bank]) begin
               w_state_nxt = S_STREAM;
            end
         end
         S_STREAM: begin
            w_rd_en = w_rd_ok;
            if (w_rd_ok && (r_offset == LP_OFS_MAX)) begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (w_pop && w_head_last) begin
               w_state_nxt = S_RELEASE;
            end
         end
         S_RELEASE: begin
            w_release   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register, bank pointer and read offset.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_state    <= S_IDLE;
         r_cur_bank <= 1'b0;
         r_offset   <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == S_RELEASE) begin
            r_cur_bank <= ~r_cur_bank;
            r_offset   <= '0;
         end else if (w_rd_en && (r_offset != LP_OFS_MAX)) begin
            r_offset <= r_offset + 1'b1;
         end
      end
   end

   // Track the read in flight so its data is captured exactly one cycle later.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_rd_pend   <= 1'b0;
         r_pend_last <= 1'b0;
      end else begin
         r_rd_pend   <= w_rd_en;
         r_pend_last <= w_rd_en && (r_offset == LP_OFS_MAX);
      end
   end

   // Skid FIFO: push returning RAM data, pop on downstream handshake.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         r_mem_data[0] <= '0;
         r_mem_data[1] <= '0;
         r_mem_last    <= 2'b00;
         r_wptr        <= 1'b0;
         r_rptr        <= 1'b0;
         r_count       <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem_data[r_wptr] <= bus.ram_rd_data;
            r_mem_last[r_wptr] <= r_pend_last;
            r_wptr             <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      end
   end

   assign bus.ram_rd_en    = w_rd_en;
   assign bus.ram_rd_addr  = {r_cur_bank, r_offset};
   assign bus.rd_data      = r_mem_data[r_rptr];
   assign bus.rd_valid     = w_valid;
   assign bus.rd_last      = w_head_last & w_valid;
   assign bus.bank_release = w_release ? (r_cur_bank ? 2'b10 : 2'b01) : 2'b00;
   assign bus.cur_bank     = r_cur_bank;
   assign bus.busy         = (r_state != S_IDLE);
   assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_ping_pang_reader.sv
// Self-checking bench for ping_pang_reader: RAM model, writer and consumer
// drivers, and a cycle-level reference model of the bank hand-off protocol.
module tb_ping_pang_reader;
   localparam int DATA_W = 8;
   localparam int OFS_W  = 7;
   localparam int DEPTH  = 128;

   // ---------------- clock / reset ----------------
   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [1:0] dbg_state;

   always #5 sys_clk = ~sys_clk;

   ping_pang_reader_if #(.DATA_W(DATA_W), .OFS_W(OFS_W)) bus ();

   ping_pang_reader #(.DATA_W(DATA_W), .OFS_W(OFS_W)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ---------------- RAM model (1-cycle read latency) ----------------
   logic [DATA_W-1:0] ram [0:255];

   always @(posedge sys_clk) begin
      if (bus.ram_rd_en) bus.ram_rd_data <= ram[bus.ram_rd_addr];
   end

   // ---------------- downstream consumer ----------------
   // 0: always ready, 1: random 50%, 2: stall 5 cycles on the last word
   int ready_mode = 0;
   int hold_cnt   = 0;

   always @(posedge sys_clk) begin
      #1;
      case (ready_mode)
         0: bus.rd_ready = 1'b1;
         1: bus.rd_ready = ($urandom_range(0, 1) == 1);
         default: begin
            if (bus.rd_valid && bus.rd_last && hold_cnt < 5) begin
               bus.rd_ready = 1'b0;
               hold_cnt++;
            end else begin
               bus.rd_ready = 1'b1;
            end
         end
      endcase
      if (ready_mode != 2) hold_cnt = 0;
   end

   // ---------------- scoreboard ----------------
   logic [DATA_W:0] exp_q [$];
   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      n_cmp++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Reference model: 0 = waiting for the expected bank, 1 = bank active,
   // 2 = release cycle expected.
   int              phase     = 0;
   logic            nb        = 1'b0;
   int              cyc       = 0;
   int              off       = 0;
   int              popped    = 0;
   bit              all_ready = 1'b0;
   bit              rst_prev  = 1'b0;
   bit              hold_prev = 1'b0;
   logic [DATA_W:0] held_word = '0;
   logic [DATA_W:0] w;
   bit              end_req   = 1'b0;
   bit              end_ack   = 1'b0;

   always @(negedge sys_clk) begin
      if (sys_rst) begin
         if (rst_prev)
            check("reset_outputs",
                  32'({bus.ram_rd_en, bus.ram_rd_addr, bus.rd_data, bus.rd_valid,
                       bus.rd_last, bus.bank_release, bus.cur_bank, bus.busy}), 32'd0);
         exp_q.delete();
         phase     = 0;
         nb        = 1'b0;
         hold_prev = 1'b0;
      end else begin
         if (hold_prev)
            check("hold_stable", 32'({bus.rd_valid, bus.rd_last, bus.rd_data}),
                  32'({1'b1, held_word}));
         case (phase)
            0: begin
               check("idle_quiet",
                     32'({bus.busy, bus.ram_rd_en, bus.rd_valid, bus.bank_release, bus.cur_bank}),
                     32'({5'b0, nb}));
               if (bus.bank_full[nb]) begin
                  for (int i = 0; i < DEPTH; i++) begin
                     int idx;
                     idx = (nb ? DEPTH : 0) + i;
                     exp_q.push_back({i == DEPTH - 1, ram[idx[7:0]]});
                  end
                  phase     = 1;
                  cyc       = 0;
                  off       = 0;
                  popped    = 0;
                  all_ready = 1'b1;
               end
            end
            1: begin
               cyc++;
               if (bus.rd_valid && !bus.rd_ready) all_ready = 1'b0;
               check("no_release_mid_drain", 32'(bus.bank_release), 32'd0);
               if (cyc == 1) check("first_read_latency", 32'(bus.ram_rd_en), 32'd1);
               if (cyc == 2) check("valid_before_t3", 32'(bus.rd_valid), 32'd0);
               if (cyc == 3) check("valid_at_t3", 32'(bus.rd_valid), 32'd1);
               if (bus.ram_rd_en) begin
                  check("read_addr", 32'({1'b0, bus.ram_rd_addr}),
                        32'({off >= DEPTH, nb, off[OFS_W-1:0]}));
                  off++;
               end
               if (bus.rd_valid && bus.rd_ready) begin
                  popped++;
                  if (exp_q.size() == 0) begin
                     check("unexpected_word", 32'({bus.rd_last, bus.rd_data}), 32'hFFFF_FFFF);
                  end else begin
                     w = exp_q.pop_front();
                     check("word", 32'({bus.rd_last, bus.rd_data}), 32'(w));
                     if (w[DATA_W]) begin
                        check("reads_issued", off, DEPTH);
                        if (all_ready) check("stream_cycles", cyc, DEPTH + 2);
                        phase = 2;
                     end
                  end
               end
               check("skid_occupancy", 32'(off - popped <= 2), 32'd1);
               if (cyc > 4000) begin
                  check("drain_timeout", cyc, 0);
                  exp_q.delete();
                  phase = 0;
               end
            end
            default: begin
               check("release_pulse", 32'({bus.busy, bus.ram_rd_en, bus.bank_release}),
                     32'({1'b1, 1'b0, (nb ? 2'b10 : 2'b01)}));
               nb    = ~nb;
               phase = 0;
            end
         endcase
         hold_prev = bus.rd_valid && !bus.rd_ready;
         held_word = {bus.rd_last, bus.rd_data};
         if (end_req && !end_ack) begin
            check("queue_empty", exp_q.size(), 0);
            check("ended_idle", phase, 0);
            end_ack = 1'b1;
         end
      end
      rst_prev = sys_rst;
   end

   // ---------------- driver tasks ----------------
   task automatic do_reset();
      @(posedge sys_clk); #1;
      sys_rst = 1'b1;
      repeat (2) @(posedge sys_clk);
      #1;
      sys_rst = 1'b0;
   endtask

   task automatic fill_bank(input int b);
      @(posedge sys_clk); #1;
      for (int i = 0; i < DEPTH; i++) begin
         int idx;
         idx = b * DEPTH + i;
         ram[idx[7:0]] = DATA_W'($urandom_range(0, 255));
      end
      bus.bank_full[b] = 1'b1;
   endtask

   task automatic wait_release(input int b);
      for (int i = 0; i < 3000; i++) begin
         @(posedge sys_clk); #1;
         if (bus.bank_release[b]) begin
            bus.bank_full[b] = 1'b0;
            break;
         end
      end
   endtask

   task automatic wait_words(input int n);
      int seen;
      seen = 0;
      for (int i = 0; i < 2000 && seen < n; i++) begin
         @(negedge sys_clk);
         if (bus.rd_valid && bus.rd_ready) seen++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bus.bank_full = 2'b00;
      do_reset();

      // single bank, full throughput
      ready_mode = 0;
      fill_bank(0);
      wait_release(0);

      // only bank 1 full after reset: nothing may happen until bank 0 arrives
      do_reset();
      fill_bank(1);
      repeat (20) @(posedge sys_clk);
      fill_bank(0);
      wait_release(0);
      wait_release(1);

      // both banks full, then a third drain back on bank 0
      fill_bank(0);
      fill_bank(1);
      wait_release(0);
      wait_release(1);
      fill_bank(0);
      wait_release(0);

      // random backpressure on both banks
      ready_mode = 1;
      fill_bank(1);
      wait_release(1);
      fill_bank(0);
      wait_release(0);

      // reset in the middle of bank 0, then the drain restarts from 0x00
      ready_mode = 0;
      do_reset();
      fill_bank(0);
      wait_words(40);
      do_reset();
      wait_release(0);

      // stall on the last word before releasing
      ready_mode = 2;
      fill_bank(1);
      wait_release(1);
      ready_mode = 0;

      repeat (5) @(posedge sys_clk);
      end_req = 1'b1;
      for (int i = 0; i < 10 && !end_ack; i++) @(posedge sys_clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
